// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------------------
// fetch_sequencer_if
// Instruction-memory request bus between the fetch sequencer and imem.
//   imem_req_o    sequencer -> imem  fetch request, held until acknowledged
//   imem_addr_o   sequencer -> imem  word address, stable while imem_req_o high
//   imem_ack_i    imem -> sequencer  request accepted, imem_rdata_i valid
//   imem_rdata_i  imem -> sequencer  fetched instruction word
// master modport: the fetch sequencer; slave modport: the instruction memory.
// ---------------------------------------------------------------------------
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_ack_i;
  logic [31:0]       imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller. Owns the word-addressed programme counter,
// issues requests to instruction memory over a req/ack handshake and hands
// fetched words to decode through a 1-entry output slot backed by a 1-entry
// skid buffer. Applies branch redirects, kills stale fetches, and honours
// decode stall and halt.
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   stall_i             decode cannot accept the slot this cycle
//   redirect_valid_i    1-cycle pulse, refetch from redirect_target_i
//   redirect_target_i   redirect address
//   halt_i              stop fetching once the outstanding request retires
//   imem                request bus to instruction memory (master side)
//   if_valid_o          output slot holds an instruction
//   if_pc_o/if_instr_o  PC and instruction word in the slot
//   flush_o             registered 1-cycle pulse that kills IF/ID downstream
//   halted_o            fetch has stopped
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  input  logic              halt_i,
  fetch_sequencer_if.master imem,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_instr_o,
  output logic              flush_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              discard;
  logic              flush;
  logic              halted;

  logic              slot_valid;
  logic [ADDR_W-1:0] slot_pc;
  logic [31:0]       slot_instr;
  logic              skid_valid;
  logic [ADDR_W-1:0] skid_pc;
  logic [31:0]       skid_instr;

  logic              ack;
  logic              consume;
  logic              deliver;
  logic              take_redirect;
  logic              skid_next_valid;

  // An ack only counts while a request is actually outstanding, so a stray
  // ack after reset or in HALTED is ignored. Only FETCH delivers data; the
  // ack that retires a killed request in DRAIN is swallowed.
  assign ack           = req & imem.imem_ack_i;
  assign consume       = slot_valid & ~stall_i;
  assign deliver       = ack & (state == FETCH) & ~discard;
  assign take_redirect = redirect_valid_i & (state != HALTED);
  assign pc_inc        = pc + ADDR_W'(1);

  // Skid occupancy after this edge. A new request is only issued when it
  // will be empty, which guarantees the skid never has to hold two words.
  assign skid_next_valid = consume ? (skid_valid & deliver)
                                   : (skid_valid | (deliver & slot_valid));

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = addr;
  assign if_valid_o       = slot_valid;
  assign if_pc_o          = slot_pc;
  assign if_instr_o       = slot_instr;
  assign flush_o          = flush;
  assign halted_o         = halted;

  // Sequencer state, PC, request handshake and the slot/skid pair.
  // A redirect wins over everything else: it empties slot and skid, pulses
  // flush and retargets the PC. If it catches a request mid-flight the
  // request must stay up until acked, so we park in DRAIN and drop that
  // ack. Otherwise, in FETCH a request is held until acked, and a new one
  // is raised whenever the skid will be empty and halt is not requested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_VEC;
      req        <= 1'b0;
      addr       <= RESET_VEC;
      discard    <= 1'b0;
      flush      <= 1'b0;
      halted     <= 1'b0;
      slot_valid <= 1'b0;
      slot_pc    <= '0;
      slot_instr <= '0;
      skid_valid <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      flush <= 1'b0;
      if (take_redirect) begin
        flush      <= 1'b1;
        slot_valid <= 1'b0;
        skid_valid <= 1'b0;
        pc         <= redirect_target_i;
        if (req && !ack) begin
          state   <= DRAIN;
          discard <= 1'b1;
        end else begin
          state   <= FETCH;
          discard <= 1'b0;
          req     <= 1'b0;
        end
      end else begin
        if (consume) begin
          if (skid_valid) begin
            slot_pc    <= skid_pc;
            slot_instr <= skid_instr;
            skid_valid <= deliver;
            if (deliver) begin
              skid_pc    <= addr;
              skid_instr <= imem.imem_rdata_i;
            end
          end else begin
            slot_valid <= deliver;
            if (deliver) begin
              slot_pc    <= addr;
              slot_instr <= imem.imem_rdata_i;
            end
          end
        end else if (deliver) begin
          if (!slot_valid) begin
            slot_valid <= 1'b1;
            slot_pc    <= addr;
            slot_instr <= imem.imem_rdata_i;
          end else begin
            skid_valid <= 1'b1;
            skid_pc    <= addr;
            skid_instr <= imem.imem_rdata_i;
          end
        end

        case (state)
          IDLE: begin
            state <= FETCH;
          end
          FETCH: begin
            if (ack) begin
              pc <= pc_inc;
            end
            if (req && !ack) begin
              req <= 1'b1;
            end else if (halt_i) begin
              req    <= 1'b0;
              state  <= HALTED;
              halted <= 1'b1;
            end else if (!skid_next_valid) begin
              req  <= 1'b1;
              addr <= ack ? pc_inc : pc;
            end else begin
              req <= 1'b0;
            end
          end
          DRAIN: begin
            if (ack) begin
              req     <= 1'b0;
              discard <= 1'b0;
              state   <= halt_i ? HALTED : FETCH;
              halted  <= halt_i;
            end
          end
          HALTED: begin
            req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. The bench plays instruction
// memory (word at address a is mem_word(a)) with randomised ack timing and
// randomised decode stall / redirect traffic. A transaction-level reference
// tracks the PC decode must see next: every consumed slot must carry that
// PC and its memory word, a redirect retargets it, and flush_o must follow
// an accepted redirect by one cycle. A second instance with
// RESET_VEC = 32'hFFFF_FFFF covers PC wrap and reset during a request.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        halt_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        flush_o;
  logic        halted_o;

  logic        reset_w;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;
  logic        w_flush;
  logic        w_halted;

  fetch_sequencer_if #(.ADDR_W(32)) bus ();
  fetch_sequencer_if #(.ADDR_W(32)) w_bus ();

  fetch_sequencer #(.ADDR_W(32), .RESET_VEC(32'h0000_0000)) dut (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .halt_i            (halt_i),
    .imem              (bus.master),
    .if_valid_o        (if_valid_o),
    .if_pc_o           (if_pc_o),
    .if_instr_o        (if_instr_o),
    .flush_o           (flush_o),
    .halted_o          (halted_o)
  );

  fetch_sequencer #(.ADDR_W(32), .RESET_VEC(32'hFFFF_FFFF)) dut_w (
    .clk               (clk),
    .reset             (reset_w),
    .stall_i           (1'b0),
    .redirect_valid_i  (1'b0),
    .redirect_target_i (32'h0),
    .halt_i            (1'b0),
    .imem              (w_bus.master),
    .if_valid_o        (w_if_valid),
    .if_pc_o           (w_if_pc),
    .if_instr_o        (w_if_instr),
    .flush_o           (w_flush),
    .halted_o          (w_halted)
  );

  always #5 clk = ~clk;

  int          compared   = 0;
  int          mismatched = 0;
  int          stall_pct;
  int          ack_pct;
  int          redir_pct;
  bit          force_redir;
  logic [31:0] force_target;
  logic [31:0] exp_pc;
  int          consumed;
  bit          prev_hold;
  logic [31:0] prev_addr;

  // Contents of instruction memory: distinct per address so a stale or
  // misplaced word is visible.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ (a << 3) ^ 32'hC0DE_1234;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // One clock cycle of traffic, entered and left at a falling edge. Inputs
  // for the coming rising edge are picked, the reference consumes the slot
  // if decode takes it, and after the edge flush and request stability are
  // checked against what this cycle implied.
  task automatic applyStimulus();
    bit taken;
    stall_i          = ($urandom_range(99) < stall_pct);
    redirect_valid_i = 1'b0;
    if (force_redir) begin
      redirect_valid_i  = 1'b1;
      redirect_target_i = force_target;
      force_redir       = 1'b0;
    end else if ($urandom_range(99) < redir_pct) begin
      redirect_valid_i  = 1'b1;
      redirect_target_i = $urandom;
    end
    bus.imem_ack_i   = ($urandom_range(99) < ack_pct);
    bus.imem_rdata_i = mem_word(bus.imem_addr_o);

    taken = redirect_valid_i && !halted_o;
    if (taken) begin
      exp_pc = redirect_target_i;
    end else if (if_valid_o && !stall_i) begin
      checkOutput("if_pc", if_pc_o, exp_pc);
      checkOutput("if_instr", if_instr_o, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd1;
      consumed++;
    end
    prev_hold = bus.imem_req_o && !bus.imem_ack_i;
    prev_addr = bus.imem_addr_o;

    @(negedge clk);
    checkOutput("flush", 32'(flush_o), 32'(taken));
    if (prev_hold) begin
      checkOutput("req_hold", 32'(bus.imem_req_o), 32'd1);
      checkOutput("addr_hold", bus.imem_addr_o, prev_addr);
    end
    if (halted_o) begin
      checkOutput("halted_req", 32'(bus.imem_req_o), 32'd0);
    end
  endtask

  initial begin
    int          c;
    int          got;
    logic [31:0] halt_addr;
    logic [31:0] w_pcs [2];

    reset             = 1'b1;
    reset_w           = 1'b1;
    stall_i           = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_target_i = '0;
    halt_i            = 1'b0;
    bus.imem_ack_i    = 1'b0;
    bus.imem_rdata_i  = '0;
    w_bus.imem_ack_i  = 1'b0;
    w_bus.imem_rdata_i = '0;
    force_redir       = 1'b0;
    force_target      = '0;
    stall_pct         = 0;
    ack_pct           = 0;
    redir_pct         = 0;
    repeat (2) @(negedge clk);

    checkOutput("rst_req", 32'(bus.imem_req_o), 32'd0);
    checkOutput("rst_addr", bus.imem_addr_o, 32'd0);
    checkOutput("rst_valid", 32'(if_valid_o), 32'd0);
    checkOutput("rst_pc", if_pc_o, 32'd0);
    checkOutput("rst_instr", if_instr_o, 32'd0);
    checkOutput("rst_flush", 32'(flush_o), 32'd0);
    checkOutput("rst_halted", 32'(halted_o), 32'd0);

    reset    = 1'b0;
    exp_pc   = 32'd0;
    consumed = 0;

    $display("[TB] zero-wait fetch from reset");
    ack_pct = 100;
    for (int i = 0; i < 10 && consumed == 0; i++) applyStimulus();
    checkOutput("first_fetch", 32'(consumed > 0), 32'd1);
    c = consumed;
    repeat (3) applyStimulus();
    checkOutput("zero_wait_rate", 32'(consumed - c), 32'd3);

    $display("[TB] stall with slot and skid full");
    stall_pct = 100;
    repeat (3) applyStimulus();
    checkOutput("stall_req", 32'(bus.imem_req_o), 32'd0);
    checkOutput("stall_valid", 32'(if_valid_o), 32'd1);
    checkOutput("stall_pc", if_pc_o, exp_pc);
    stall_pct = 0;
    ack_pct   = 0;
    c = consumed;
    repeat (2) applyStimulus();
    checkOutput("skid_drain", 32'(consumed - c), 32'd2);

    $display("[TB] redirect while request pending");
    checkOutput("req_pending", 32'(bus.imem_req_o), 32'd1);
    force_redir  = 1'b1;
    force_target = 32'h40;
    applyStimulus();
    applyStimulus();
    ack_pct = 100;
    c = consumed;
    repeat (6) applyStimulus();
    checkOutput("redir_progress", 32'(consumed > c), 32'd1);

    $display("[TB] redirect in the same cycle as ack");
    checkOutput("req_before_redirect", 32'(bus.imem_req_o), 32'd1);
    force_redir  = 1'b1;
    force_target = 32'h80;
    applyStimulus();
    checkOutput("no_drain", 32'(bus.imem_req_o), 32'd0);
    c = consumed;
    repeat (6) applyStimulus();
    checkOutput("redir_ack_progress", 32'(consumed > c), 32'd1);

    $display("[TB] random traffic");
    ack_pct   = 60;
    stall_pct = 30;
    redir_pct = 5;
    c = consumed;
    repeat (400) applyStimulus();
    checkOutput("random_progress", 32'(consumed - c > 20), 32'd1);

    $display("[TB] halt with outstanding request");
    redir_pct = 0;
    stall_pct = 0;
    ack_pct   = 100;
    repeat (4) applyStimulus();
    checkOutput("req_before_halt", 32'(bus.imem_req_o), 32'd1);
    halt_addr = bus.imem_addr_o;
    halt_i    = 1'b1;
    ack_pct   = 0;
    repeat (2) applyStimulus();
    ack_pct = 100;
    for (int i = 0; i < 10 && !halted_o; i++) applyStimulus();
    checkOutput("halted", 32'(halted_o), 32'd1);
    repeat (4) applyStimulus();
    checkOutput("halt_drained", 32'(if_valid_o), 32'd0);
    checkOutput("halt_last_pc", exp_pc, halt_addr + 32'd1);
    force_redir  = 1'b1;
    force_target = 32'h100;
    applyStimulus();
    applyStimulus();
    checkOutput("halt_redir_valid", 32'(if_valid_o), 32'd0);
    checkOutput("halt_redir_req", 32'(bus.imem_req_o), 32'd0);
    checkOutput("halt_sticky", 32'(halted_o), 32'd1);

    $display("[TB] reset during a request");
    halt_i = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    exp_pc  = 32'd0;
    ack_pct = 0;
    for (int i = 0; i < 8 && !bus.imem_req_o; i++) applyStimulus();
    checkOutput("req_up", 32'(bus.imem_req_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_req", 32'(bus.imem_req_o), 32'd0);
    checkOutput("mid_rst_addr", bus.imem_addr_o, 32'd0);
    checkOutput("mid_rst_valid", 32'(if_valid_o), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    exp_pc  = 32'd0;
    ack_pct = 100;
    c = consumed;
    repeat (8) applyStimulus();
    checkOutput("post_rst_progress", 32'(consumed > c), 32'd1);

    $display("[TB] PC wrap from RESET_VEC=FFFFFFFF");
    reset_w = 1'b0;
    got = 0;
    for (int i = 0; i < 12 && got < 2; i++) begin
      w_bus.imem_ack_i   = 1'b1;
      w_bus.imem_rdata_i = mem_word(w_bus.imem_addr_o);
      if (w_if_valid) begin
        w_pcs[got] = w_if_pc;
        checkOutput("wrap_instr", w_if_instr, mem_word(w_if_pc));
        got++;
      end
      @(negedge clk);
    end
    checkOutput("wrap_count", 32'(got), 32'd2);
    checkOutput("wrap_pc0", w_pcs[0], 32'hFFFF_FFFF);
    checkOutput("wrap_pc1", w_pcs[1], 32'h0000_0000);
    checkOutput("w_req_before", 32'(w_bus.imem_req_o), 32'd1);
    #2 reset_w = 1'b1;
    #1;
    checkOutput("w_rst_req", 32'(w_bus.imem_req_o), 32'd0);
    checkOutput("w_rst_addr", w_bus.imem_addr_o, 32'hFFFF_FFFF);
    checkOutput("w_rst_valid", 32'(w_if_valid), 32'd0);
    checkOutput("w_rst_pc", w_if_pc, 32'd0);
    @(negedge clk);
    checkOutput("w_stray_ack", 32'(w_if_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
